pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock (rising edge); nRST  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: ihit  in  1  instruction fetch complete this cycle; dmem_req  in  1  MEM stage holds a load/store; dhit  in  1  data access complete this cycle.
REQ-003 SHALL have ports: ex_redirect  in  1  taken branch resolved in EX; ex_jr  in  1  JR resolved in EX; id_jump  in  1  J/JAL decoded in ID; load_use  in  1  load-use hazard detected in ID; wb_halt  in  1  HALT instruction reached WB.
REQ-004 SHALL have ports: pcenable  out  1  PC register load; pcsrc  out  2  PC mux select (00 +4, 01 JR, 10 branch, 11 jump); iREN  out  1  instruction read enable.
REQ-005 SHALL have ports: stall_ifid  out  1; flush_ifid  out  1; flush_idex  out  1; stall_idex  out  1; halted  out  1  core stopped.
REQ-006 SHALL, when PC_SEQ_PERF_EN is defined, additionally have fetch_count  out  32 and stall_count  out  32.

Function
REQ-007 SHALL implement FSM states FETCH, DWAIT, REDIRECT, HALTED; encoding free.
REQ-008 FETCH: iREN=1; pcenable=1 only when ihit=1, dmem_req&!dhit=0, load_use=0 (or load_use overridden per REQ-012).
REQ-009 pcsrc priority in FETCH: ex_jr -> 01; else ex_redirect -> 10; else id_jump -> 11; else 00.
REQ-010 EX redirect (ex_jr|ex_redirect) with ihit=1: pcenable=1, flush_ifid=1, flush_idex=1 same cycle; stay FETCH.
REQ-011 id_jump alone with ihit=1: pcenable=1, flush_ifid=1, flush_idex=0.
REQ-012 load_use=1 with no redirect: pcenable=0, stall_ifid=1, flush_idex=1 (bubble); if EX redirect also asserted, redirect wins and load_use is ignored.
REQ-013 Redirect (any of REQ-009 sources) with ihit=0: latch selected pcsrc into pend_src, go REDIRECT; pcenable=0, stall_ifid=1.
REQ-014 REDIRECT: iREN=1, pcsrc=pend_src, redirect inputs ignored; on ihit=1 -> pcenable=1, flush_ifid=1, flush_idex per REQ-010/011 for pend_src, return FETCH.
REQ-015 dmem_req=1 and dhit=0 in FETCH: go DWAIT; pcenable=0, iREN=0, stall_ifid=1, stall_idex=1.
REQ-016 DWAIT: outputs as REQ-015; on dhit=1 return FETCH next cycle, no fetch issued in the dhit cycle.
REQ-017 Data access has priority over fetch: dmem_req&!dhit together with a redirect enters DWAIT and latches pend_src; on dhit go REDIRECT, not FETCH.
REQ-018 wb_halt=1 in any state: go HALTED next cycle, outputs of that cycle as FETCH but pcenable=0; halt wins over all simultaneous events.
REQ-019 HALTED: halted=1, pcenable=0, iREN=0, stall_ifid=1, stall_idex=1, all flushes 0; exit only by reset.
REQ-020 All outputs other than counters SHALL be combinational from state and inputs; state and pend_src registered.

Reset
REQ-021 nRST=0 SHALL asynchronously force state=FETCH, pend_src=00, counters=0.
REQ-022 During reset pcenable=0, iREN=0, halted=0, all stall/flush outputs 0, pcsrc=00.
REQ-023 Reset asserted mid-DWAIT or mid-REDIRECT SHALL discard pending redirect; first cycle after release issues a fresh fetch.

Configuration
REQ-024 Macro PC_SEQ_PERF_EN defined: fetch_count increments by 1 each cycle pcenable=1; stall_count increments each cycle not HALTED with pcenable=0; both wrap 0xFFFFFFFF -> 0 and freeze in HALTED.
REQ-025 Macro undefined: counter ports and registers absent; all other behaviour identical.

Verification
REQ-026 Reset then ihit=1 for 4 cycles, no hazards -> pcenable=1 each cycle, pcsrc=00, fetch_count=4.
REQ-027 ex_jr=1 and id_jump=1 same cycle with ihit=1 -> pcsrc=01, flush_ifid=1, flush_idex=1, pcenable=1.
REQ-028 ex_redirect=1, ihit=0 for 3 cycles then 1 -> REDIRECT held, pcsrc=10 all 4 cycles, pcenable=1 only in cycle 4 with flush_ifid=1.
REQ-029 dmem_req=1, dhit=0 for 2 cycles then 1 -> iREN=0, stall_idex=1 for 3 cycles, fetch resumes cycle 4; stall_count=3.
REQ-030 wb_halt=1 coincident with ex_redirect=1 -> next cycle halted=1, pcenable=0 thereafter; nRST pulse returns to FETCH with halted=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencing and fetch-side hazard control: PC mux select/enable, IF/ID and ID/EX stall/flush, halt.
// Optional PC_SEQ_PERF_EN adds free-running fetch_count / stall_count performance counters.
module pc_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dmem_req,
  input  logic        dhit,
  input  logic        ex_redirect,
  input  logic        ex_jr,
  input  logic        id_jump,
  input  logic        load_use,
  input  logic        wb_halt,
  output logic        pcenable,
  output logic [1:0]  pcsrc,
  output logic        iREN,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        stall_idex,
  output logic        halted
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {FETCH, DWAIT, REDIRECT, HALTED} state_t;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_JR   = 2'b01;
  localparam logic [1:0] SRC_BR   = 2'b10;
  localparam logic [1:0] SRC_JUMP = 2'b11;

  state_t     state, next_state;
  logic [1:0] pend_src, next_pend;
  logic [1:0] sel;
  logic       dstall, ex_re;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      pend_src <= '0;
    end else begin
      state    <= next_state;
      pend_src <= next_pend;
    end
  end

  always_comb begin
    pcenable   = 1'b0;
    pcsrc      = SRC_SEQ;
    iREN       = 1'b0;
    stall_ifid = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    stall_idex = 1'b0;
    halted     = 1'b0;
    next_state = state;
    next_pend  = pend_src;

    dstall = dmem_req & ~dhit;
    ex_re  = ex_jr | ex_redirect;
    if (ex_jr)            sel = SRC_JR;
    else if (ex_redirect) sel = SRC_BR;
    else if (id_jump)     sel = SRC_JUMP;
    else                  sel = SRC_SEQ;

    case (state)
      FETCH: begin
        iREN  = 1'b1;
        pcsrc = sel;
        if (dstall) begin
          // data access wins; any redirect is parked in pend_src until dhit
          iREN       = 1'b0;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          next_pend  = sel;
          next_state = DWAIT;
        end else if (ex_re) begin
          if (ihit) begin
            pcenable   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else begin
            stall_ifid = 1'b1;
            next_pend  = sel;
            next_state = REDIRECT;
          end
        end else if (load_use) begin
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (id_jump) begin
          if (ihit) begin
            pcenable   = 1'b1;
            flush_ifid = 1'b1;
          end else begin
            stall_ifid = 1'b1;
            next_pend  = sel;
            next_state = REDIRECT;
          end
        end else begin
          pcenable = ihit;
        end
      end
      REDIRECT: begin
        iREN  = 1'b1;
        pcsrc = pend_src;
        if (dstall) begin
          iREN       = 1'b0;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          next_state = DWAIT;
        end else if (ihit) begin
          pcenable   = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = (pend_src != SRC_JUMP);
          next_pend  = '0;
          next_state = FETCH;
        end else begin
          stall_ifid = 1'b1;
        end
      end
      DWAIT: begin
        pcsrc      = pend_src;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
        if (dhit) next_state = (pend_src != SRC_SEQ) ? REDIRECT : FETCH;
      end
      HALTED: begin
        halted     = 1'b1;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    if (wb_halt) begin
      pcenable   = 1'b0;
      next_state = HALTED;
    end

    if (!nRST) begin
      pcenable   = 1'b0;
      pcsrc      = SRC_SEQ;
      iREN       = 1'b0;
      stall_ifid = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      stall_idex = 1'b0;
      halted     = 1'b0;
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else if (state != HALTED) begin
      if (pcenable) fetch_count <= fetch_count + 32'd1;
      else          stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected output vectors queued at drive time, popped and checked mid-cycle.
module tb_pc_sequencer;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b0, dmem_req = 1'b0, dhit = 1'b0, ex_redirect = 1'b0;
  logic       ex_jr = 1'b0, id_jump = 1'b0, load_use = 1'b0, wb_halt = 1'b0;
  logic       pcenable, iREN, stall_ifid, flush_ifid, flush_idex, stall_idex, halted;
  logic [1:0] pcsrc;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int unsigned cmp = 0;
  int unsigned mis = 0;
  int unsigned fc = 0;
  int unsigned sc = 0;
  logic [8:0]  sb[$];

  pc_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .ex_redirect(ex_redirect), .ex_jr(ex_jr), .id_jump(id_jump), .load_use(load_use),
    .wb_halt(wb_halt), .pcenable(pcenable), .pcsrc(pcsrc), .iREN(iREN),
    .stall_ifid(stall_ifid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .stall_idex(stall_idex), .halted(halted)
`ifdef PC_SEQ_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  // input bits: {rst_n, ihit, dmem_req, dhit, ex_redirect, ex_jr, id_jump, load_use, wb_halt}
  // expected bits: {pcenable, pcsrc[1:0], iREN, stall_ifid, flush_ifid, flush_idex, stall_idex, halted}
  task automatic step(input string tag, input logic [8:0] in, input logic [8:0] exp);
    logic [8:0] obs, want;
    @(negedge CLK);
    {nRST, ihit, dmem_req, dhit, ex_redirect, ex_jr, id_jump, load_use, wb_halt} = in;
    sb.push_back(exp);
    if (!in[8]) begin
      fc = 0;
      sc = 0;
    end else if (exp[8]) fc++;
    else if (!exp[0]) sc++;
    #2;
    obs = {pcenable, pcsrc, iREN, stall_ifid, flush_ifid, flush_idex, stall_idex, halted};
    want = sb.pop_front();
    cmp++;
    assert (obs === want) else begin
      mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
    @(posedge CLK);
  endtask

  task automatic chk_cnt(input string tag);
`ifdef PC_SEQ_PERF_EN
    #2;
    cmp++;
    assert (fetch_count === fc) else begin
      mis++;
      $error("FAIL %s_fetch: observed %0d expected %0d", tag, fetch_count, fc);
    end
    cmp++;
    assert (stall_count === sc) else begin
      mis++;
      $error("FAIL %s_stall: observed %0d expected %0d", tag, stall_count, sc);
    end
`else
    #2;
    if (tag.len() == 0) $display("empty counter tag");
`endif
  endtask

  initial begin
    //            rst ih dm dh br jr jp lu hl          pe src ir si fi fx sx h
    step("reset",    9'b0_1_0_0_0_0_0_0_0, 9'b0_00_0_0_0_0_0_0);
    step("seq1",     9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    step("seq2",     9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    step("seq3",     9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    step("seq4",     9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    chk_cnt("after_seq");
    step("jr_jump",  9'b1_1_0_0_0_1_1_0_0, 9'b1_01_1_0_1_1_0_0);
    step("jump",     9'b1_1_0_0_0_0_1_0_0, 9'b1_11_1_0_1_0_0_0);
    step("load_use", 9'b1_1_0_0_0_0_0_1_0, 9'b0_00_1_1_0_1_0_0);
    step("lu_br",    9'b1_1_0_0_1_0_0_1_0, 9'b1_10_1_0_1_1_0_0);
    step("br_miss1", 9'b1_0_0_0_1_0_0_0_0, 9'b0_10_1_1_0_0_0_0);
    step("br_miss2", 9'b1_0_0_0_1_0_0_0_0, 9'b0_10_1_1_0_0_0_0);
    step("br_miss3", 9'b1_0_0_0_1_0_0_0_0, 9'b0_10_1_1_0_0_0_0);
    step("br_hit",   9'b1_1_0_0_1_0_0_0_0, 9'b1_10_1_0_1_1_0_0);
    step("seq5",     9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    step("jmp_miss", 9'b1_0_0_0_0_0_1_0_0, 9'b0_11_1_1_0_0_0_0);
    step("jmp_hit",  9'b1_1_0_0_0_0_0_0_0, 9'b1_11_1_0_1_0_0_0);
    step("dmem1",    9'b1_1_1_0_0_0_0_0_0, 9'b0_00_0_1_0_0_1_0);
    step("dmem2",    9'b1_1_1_0_0_0_0_0_0, 9'b0_00_0_1_0_0_1_0);
    step("dmem_hit", 9'b1_1_1_1_0_0_0_0_0, 9'b0_00_0_1_0_0_1_0);
    step("dmem_res", 9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    chk_cnt("after_dmem");
    step("dm_jr",    9'b1_1_1_0_0_1_0_0_0, 9'b0_01_0_1_0_0_1_0);
    step("dm_jr_dh", 9'b1_1_1_1_0_0_0_0_0, 9'b0_01_0_1_0_0_1_0);
    step("jr_pend",  9'b1_0_0_0_0_0_0_0_0, 9'b0_01_1_1_0_0_0_0);
    step("jr_done",  9'b1_1_0_0_0_0_0_0_0, 9'b1_01_1_0_1_1_0_0);
    step("br_park",  9'b1_0_0_0_1_0_0_0_0, 9'b0_10_1_1_0_0_0_0);
    step("rst_mid",  9'b0_1_0_0_0_0_0_0_0, 9'b0_00_0_0_0_0_0_0);
    step("fresh",    9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    step("halt_br",  9'b1_1_0_0_1_0_0_0_1, 9'b0_10_1_0_1_1_0_0);
    step("halted1",  9'b1_1_0_0_0_0_0_0_0, 9'b0_00_0_1_0_0_1_1);
    step("halted2",  9'b1_1_0_0_0_1_0_0_0, 9'b0_00_0_1_0_0_1_1);
    chk_cnt("halted");
    step("rst_halt", 9'b0_1_0_0_0_0_0_0_0, 9'b0_00_0_0_0_0_0_0);
    step("restart",  9'b1_1_0_0_0_0_0_0_0, 9'b1_00_1_0_0_0_0_0);
    chk_cnt("restart");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
